// File: rtl/rd_line_sched_if.sv
// DDR read-request bus between the line scheduler and the DDR controller.
// The scheduler is the master (drives the request), the controller the slave.
interface rd_line_sched_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16
);
  logic                  ddr_rreq;
  logic [ADDR_WIDTH-1:0] ddr_raddr;
  logic [LEN_WIDTH-1:0]  ddr_rd_len;
  logic                  ddr_rrdy;
  logic                  ddr_rdone;

  modport master (
    output ddr_rreq,
    output ddr_raddr,
    output ddr_rd_len,
    input  ddr_rrdy,
    input  ddr_rdone
  );

  modport slave (
    input  ddr_rreq,
    input  ddr_raddr,
    input  ddr_rd_len,
    output ddr_rrdy,
    output ddr_rdone
  );
endinterface

// File: rtl/rd_line_sched.sv
// Display read-path DDR request scheduler: one line per request trigger,
// split into bursts of at most MAX_BURST beats, with frame-buffer index,
// partition and vertical flip latched at frame sync.
module rd_line_sched #(
  parameter int          ADDR_WIDTH      = 27,
  parameter logic [31:0] ADDR_OFFSET     = 32'h0000_0000,
  parameter int          H_NUM           = 1920,
  parameter int          V_NUM           = 1080,
  parameter int          DQ_WIDTH        = 32,
  parameter int          PIX_WIDTH       = 24,
  parameter int          LEN_WIDTH       = 16,
  parameter int          LINE_ADDR_WIDTH = 19,
  parameter int          MAX_BURST       = 64,
  parameter int          FRAME_BITS      = 2,
  parameter int          PART_BITS       = 2
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rstn,
  input  logic                  fsync,
  input  logic                  line_req,
  input  logic                  vflip,
  input  logic [PART_BITS-1:0]  part,
  input  logic [FRAME_BITS-1:0] wr_frame_idx,
  rd_line_sched_if.master       ddr_bus,
  output logic                  line_done,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun
);

  localparam int LINE_BEATS = H_NUM * PIX_WIDTH / (8 * DQ_WIDTH);
  localparam int LINE_WORDS = LINE_BEATS * 8;
  localparam int NBURST     = (LINE_BEATS + MAX_BURST - 1) / MAX_BURST;
  localparam int LAST_LEN   = LINE_BEATS - (NBURST - 1) * MAX_BURST;
  localparam int LINE_W     = $clog2(V_NUM + 1);
  localparam int BURST_W    = (NBURST > 1) ? $clog2(NBURST) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [LINE_W-1:0]       line_reg, line_next;
  logic [BURST_W-1:0]      burst_reg, burst_next;
  logic                    pend_reg, pend_next;
  logic                    overrun_reg, overrun_next;
  logic                    restart_reg, restart_next;
  logic [FRAME_BITS-1:0]   frm_reg, frm_next;
  logic [PART_BITS-1:0]    prt_reg, prt_next;
  logic                    flp_reg, flp_next;
  logic [ADDR_WIDTH-1:0]   raddr_reg, raddr_calc;
  logic [LEN_WIDTH-1:0]    rd_len_reg, rd_len_calc;

  logic                    pend_eff;
  int                      row_idx;
  logic [LINE_ADDR_WIDTH-1:0] word_off;

  // A line_req that arrives while a line is in flight: latch it once,
  // flag overrun if the latch is already occupied.
  function automatic void busy_req(input logic pend_in, inout logic pend_out,
                                   inout logic ovr_out);
    if (pend_in) ovr_out = 1'b1;
    else         pend_out = 1'b1;
  endfunction

  // Next-state logic: frame sync latching, line sequencing and burst handshake.
  always_comb begin
    state_next   = state_reg;
    line_next    = line_reg;
    burst_next   = burst_reg;
    pend_next    = pend_reg;
    overrun_next = overrun_reg;
    restart_next = restart_reg;
    frm_next     = frm_reg;
    prt_next     = prt_reg;
    flp_next     = flp_reg;
    pend_eff     = 1'b0;

    // Frame parameters are taken immediately; a restart may be deferred below.
    if (fsync) begin
      frm_next     = wr_frame_idx - FRAME_BITS'(1);
      prt_next     = part;
      flp_next     = vflip;
      line_next    = '0;
      overrun_next = 1'b0;
      pend_next    = 1'b0;
    end

    case (state_reg)
      S_IDLE: begin
        if (fsync) begin
          state_next = S_REQ;
          burst_next = '0;
        end else if (line_req && (int'(line_reg) < V_NUM)) begin
          state_next = S_REQ;
          burst_next = '0;
        end
      end

      S_REQ: begin
        if (fsync) restart_next = 1'b1;
        else if (line_req) busy_req(pend_reg, pend_next, overrun_next);
        if (ddr_bus.ddr_rrdy) state_next = S_WAIT;
      end

      S_WAIT: begin
        if (fsync) restart_next = 1'b1;
        else if (line_req) busy_req(pend_reg, pend_next, overrun_next);
        if (ddr_bus.ddr_rdone) begin
          if (restart_reg || fsync) begin
            // Outstanding burst of the old frame has drained: start line 0
            // of the new frame without reporting the abandoned line.
            restart_next = 1'b0;
            burst_next   = '0;
            state_next   = S_REQ;
          end else if (int'(burst_reg) < NBURST - 1) begin
            burst_next = burst_reg + BURST_W'(1);
            state_next = S_REQ;
          end else begin
            state_next = S_DONE;
          end
        end
      end

      S_DONE: begin
        burst_next = '0;
        if (fsync) begin
          state_next = S_REQ;
        end else begin
          line_next = line_reg + LINE_W'(1);
          pend_eff  = pend_reg | line_req;
          if (pend_reg && line_req) overrun_next = 1'b1;
          pend_next = 1'b0;
          if (pend_eff && (int'(line_reg) + 1 < V_NUM)) state_next = S_REQ;
          else                                          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Address and length of the request about to be issued, from next-state values.
  always_comb begin
    row_idx     = flp_next ? (V_NUM - 1 - int'(line_next)) : int'(line_next);
    word_off    = LINE_ADDR_WIDTH'(row_idx * LINE_WORDS + int'(burst_next) * MAX_BURST * 8);
    raddr_calc  = ADDR_WIDTH'(ADDR_OFFSET) + ADDR_WIDTH'({frm_next, prt_next, word_off});
    rd_len_calc = (int'(burst_next) == NBURST - 1) ? LEN_WIDTH'(LAST_LEN)
                                                   : LEN_WIDTH'(MAX_BURST);
  end

  // State, counters and latched frame parameters.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_reg   <= S_IDLE;
      line_reg    <= '0;
      burst_reg   <= '0;
      pend_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      restart_reg <= 1'b0;
      frm_reg     <= '0;
      prt_reg     <= '0;
      flp_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      line_reg    <= line_next;
      burst_reg   <= burst_next;
      pend_reg    <= pend_next;
      overrun_reg <= overrun_next;
      restart_reg <= restart_next;
      frm_reg     <= frm_next;
      prt_reg     <= prt_next;
      flp_reg     <= flp_next;
    end
  end

  // Request address/length are captured on entry to REQ and held until accepted.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      raddr_reg  <= '0;
      rd_len_reg <= '0;
    end else if ((state_next == S_REQ) && (state_reg != S_REQ)) begin
      raddr_reg  <= raddr_calc;
      rd_len_reg <= rd_len_calc;
    end
  end

  assign ddr_bus.ddr_rreq   = (state_reg == S_REQ);
  assign ddr_bus.ddr_raddr  = raddr_reg;
  assign ddr_bus.ddr_rd_len = rd_len_reg;

  assign line_done  = (state_reg == S_DONE);
  assign frame_done = (state_reg == S_DONE) && (int'(line_reg) == V_NUM - 1);
  assign busy       = (state_reg != S_IDLE);
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_rd_line_sched.sv
// Scoreboard bench for rd_line_sched: expected requests are queued as
// frames/lines are triggered and checked as the DDR model accepts them.
module tb_rd_line_sched;
  localparam int AW = 27;
  localparam int LW = 16;
  localparam int VN = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } req_t;

  logic       ddr_clk = 1'b0;
  logic       ddr_rstn = 1'b0;
  logic       fsync = 1'b0;
  logic       line_req = 1'b0;
  logic       vflip = 1'b0;
  logic [1:0] part = '0;
  logic [1:0] wr_frame_idx = '0;
  logic       line_done, frame_done, busy, overrun;

  rd_line_sched_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) ddr_bus ();

  rd_line_sched #(
    .ADDR_WIDTH(AW), .ADDR_OFFSET(32'h0), .H_NUM(64), .V_NUM(VN),
    .DQ_WIDTH(32), .PIX_WIDTH(32), .LEN_WIDTH(LW), .LINE_ADDR_WIDTH(19),
    .MAX_BURST(3), .FRAME_BITS(2), .PART_BITS(2)
  ) dut (
    .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn), .fsync(fsync), .line_req(line_req),
    .vflip(vflip), .part(part), .wr_frame_idx(wr_frame_idx), .ddr_bus(ddr_bus),
    .line_done(line_done), .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 ddr_clk = ~ddr_clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  int   stall_req = 0;
  req_t sb[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Model: {frame, partition, row*64 + burst*24}, 19-bit word offset.
  function automatic logic [AW-1:0] exp_addr(int frm, int prt, int flp, int line, int b);
    int row;
    row = flp ? (VN - 1 - line) : line;
    return AW'((frm << 21) | (prt << 19) | (row * 64 + b * 24));
  endfunction

  task automatic push_line(int frm, int prt, int flp, int line, int nb);
    req_t e;
    for (int b = 0; b < nb; b++) begin
      e.addr = exp_addr(frm, prt, flp, line, b);
      e.len  = (b == 2) ? LW'(2) : LW'(3);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_req();
    @(negedge ddr_clk);
    line_req = 1'b1;
    @(negedge ddr_clk);
    line_req = 1'b0;
  endtask

  task automatic pulse_fsync(input logic [1:0] w, input logic [1:0] p, input logic vf);
    @(negedge ddr_clk);
    fsync = 1'b1;
    wr_frame_idx = w;
    part = p;
    vflip = vf;
    @(negedge ddr_clk);
    fsync = 1'b0;
  endtask

  task automatic wait_ld(input string tag, input logic exp_fd, input int exp_sb);
    int n;
    n = 0;
    @(negedge ddr_clk);
    while (!line_done && n < 400) begin
      @(negedge ddr_clk);
      n++;
    end
    chk({tag, "_ld"}, line_done, 1);
    chk({tag, "_fd"}, frame_done, exp_fd);
    chk({tag, "_sb"}, sb.size(), exp_sb);
  endtask

  // DDR controller model: accepts requests (optionally stalling), returns
  // ddr_rdone three cycles after acceptance.
  initial begin
    int   rdone_cnt;
    int   stall_left;
    bit   stalling;
    bit   after_acc;
    req_t e;
    rdone_cnt = 0; stall_left = 0; stalling = 0; after_acc = 0;
    ddr_bus.ddr_rrdy  = 1'b1;
    ddr_bus.ddr_rdone = 1'b0;
    forever begin
      @(negedge ddr_clk);
      if (!ddr_rstn) begin
        ddr_bus.ddr_rrdy  = 1'b1;
        ddr_bus.ddr_rdone = 1'b0;
        rdone_cnt = 0; stall_left = 0; stalling = 0; after_acc = 0; stall_req = 0;
        continue;
      end
      ddr_bus.ddr_rdone = 1'b0;
      if (rdone_cnt > 0) begin
        rdone_cnt--;
        if (rdone_cnt == 0) ddr_bus.ddr_rdone = 1'b1;
      end
      if (after_acc) begin
        chk("rreq_drop", ddr_bus.ddr_rreq, 0);
        after_acc = 0;
      end
      if (stalling) chk("stall_rreq", ddr_bus.ddr_rreq, 1);
      if (ddr_bus.ddr_rreq) begin
        if (!stalling && stall_req > 0) begin
          stalling = 1;
          stall_left = stall_req;
          stall_req = 0;
        end
        if (stalling && stall_left > 0) begin
          if (sb.size() > 0) begin
            chk("stall_addr", ddr_bus.ddr_raddr, sb[0].addr);
            chk("stall_len", ddr_bus.ddr_rd_len, sb[0].len);
          end
          ddr_bus.ddr_rrdy = 1'b0;
          stall_left--;
        end else begin
          stalling = 0;
          ddr_bus.ddr_rrdy = 1'b1;
          if (sb.size() == 0) begin
            chk("unexp_req", ddr_bus.ddr_rreq, 0);
          end else begin
            e = sb.pop_front();
            $display("req addr=%07h len=%0d (want %07h/%0d)",
                     ddr_bus.ddr_raddr, ddr_bus.ddr_rd_len, e.addr, e.len);
            chk("raddr", ddr_bus.ddr_raddr, e.addr);
            chk("rd_len", ddr_bus.ddr_rd_len, e.len);
          end
          acc_cnt++;
          rdone_cnt = 3;
          after_acc = 1;
        end
      end
    end
  end

  // Main sequence.
  initial begin
    int acc_base;
    int n;
    repeat (3) @(negedge ddr_clk);
    chk("rst_rreq", ddr_bus.ddr_rreq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_ld", line_done, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_addr", ddr_bus.ddr_raddr, 0);
    chk("rst_len", ddr_bus.ddr_rd_len, 0);
    ddr_rstn = 1'b1;

    // Frame: wr_frame_idx=2 -> frm 1, part 1, no flip.
    push_line(1, 1, 0, 0, 3);
    pulse_fsync(2'd2, 2'd1, 1'b0);
    chk("lat_fsync", ddr_bus.ddr_rreq, 1);
    wait_ld("f1_l0", 0, 0);
    for (int l = 1; l < VN; l++) begin
      push_line(1, 1, 0, l, 3);
      pulse_req();
      chk("lat_req", ddr_bus.ddr_rreq, 1);
      wait_ld("f1_l", (l == VN - 1), 0);
    end
    acc_base = acc_cnt;
    pulse_req();
    repeat (20) @(negedge ddr_clk);
    chk("extra_req_acc", acc_cnt, acc_base);
    chk("extra_req_ovr", overrun, 0);
    chk("extra_req_busy", busy, 0);

    // Flipped frame: wr_frame_idx=0 wraps to frm 3, part 2.
    push_line(3, 2, 1, 0, 3);
    pulse_fsync(2'd0, 2'd2, 1'b1);
    wait_ld("flip_l0", 0, 0);
    for (int l = 1; l < VN; l++) begin
      push_line(3, 2, 1, l, 3);
      pulse_req();
      wait_ld("flip_l", (l == VN - 1), 0);
    end

    // Controller stalls the first request for 5 cycles.
    stall_req = 5;
    push_line(0, 0, 0, 0, 3);
    pulse_fsync(2'd1, 2'd0, 1'b0);
    wait_ld("stall", 0, 0);

    // Two line_req pulses during line 0: one pending, one overrun.
    push_line(2, 3, 0, 0, 3);
    pulse_fsync(2'd3, 2'd3, 1'b0);
    repeat (2) @(negedge ddr_clk);
    push_line(2, 3, 0, 1, 3);
    pulse_req();
    pulse_req();
    chk("ovr_set", overrun, 1);
    wait_ld("ovr_l0", 0, 3);
    @(negedge ddr_clk);
    chk("pend_no_idle", ddr_bus.ddr_rreq, 1);
    wait_ld("ovr_l1", 0, 0);
    chk("ovr_sticky", overrun, 1);

    // New frame clears overrun; a second fsync lands in WAIT of burst 1.
    acc_base = acc_cnt;
    push_line(0, 1, 0, 0, 2);
    pulse_fsync(2'd1, 2'd1, 1'b0);
    chk("ovr_clr", overrun, 0);
    n = 0;
    while (acc_cnt < acc_base + 2 && n < 200) begin
      @(negedge ddr_clk);
      n++;
    end
    chk("abort_acc", acc_cnt, acc_base + 2);
    push_line(3, 0, 0, 0, 3);
    pulse_fsync(2'd0, 2'd0, 1'b0);
    wait_ld("abort", 0, 0);

    // Reset asserted while a request is being stalled.
    stall_req = 10;
    pulse_req();
    chk("rst_pre_rreq", ddr_bus.ddr_rreq, 1);
    @(negedge ddr_clk);
    #2 ddr_rstn = 1'b0;
    #1;
    chk("async_rreq", ddr_bus.ddr_rreq, 0);
    chk("async_busy", busy, 0);
    chk("async_addr", ddr_bus.ddr_raddr, 0);
    chk("async_len", ddr_bus.ddr_rd_len, 0);
    sb.delete();
    repeat (2) @(negedge ddr_clk);
    ddr_rstn = 1'b1;
    @(negedge ddr_clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rreq", ddr_bus.ddr_rreq, 0);
    push_line(1, 0, 0, 0, 3);
    pulse_fsync(2'd2, 2'd0, 1'b0);
    chk("post_rst_lat", ddr_bus.ddr_rreq, 1);
    wait_ld("post_rst", 0, 0);

    repeat (10) @(negedge ddr_clk);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
